// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci stream blocks.
//   fib_state_e       : checker state encoding (SEED0, SEED1, TRACK, FAIL)
//   FIB_W_DEFAULT     : default term width
//   FIB_CNT_W_DEFAULT : default term-counter width
package fib_pkg;

  typedef enum logic [1:0] {
    SEED0 = 2'd0,
    SEED1 = 2'd1,
    TRACK = 2'd2,
    FAIL  = 2'd3
  } fib_state_e;

  localparam int FIB_W_DEFAULT     = 16;
  localparam int FIB_CNT_W_DEFAULT = 16;

endpackage

// File: rtl/fib_next_pair.sv
// Combinational Fibonacci step: from the last two terms {a,b} produce the next
// two terms exp1 = a+b and exp2 = b+exp1, both modulo 2^W.
// Ports:
//   a, b       : in  W  last two terms (a earlier)
//   exp1, exp2 : out W  next two terms
module fib_next_pair #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] exp1,
  output logic [W-1:0] exp2
);

  // Truncating adds give the modulo-2^W wrap the generators rely on.
  assign exp1 = a + b;
  assign exp2 = b + exp1;

endmodule

// File: rtl/fibonacci_checker.sv
// Fibonacci stream sink: accepts one or two terms per valid/ready beat,
// captures two seed terms, then checks every term against F(n+2)=F(n+1)+F(n).
// Reports lock, a saturating term count and the first mismatch (sticky).
// Build option: FIB_CHECKER_STRICT_SEED_EN -- when defined the seeds must be 1,1.
// Ports:
//   clk, rst (async, active-low), clr (sync clear)
//   in_valid/in_ready/in_dual/in_data/in_data2 : input stream
//   locked   : checking active (TRACK)
//   err, err_idx, err_got, err_exp : first mismatch record
//   term_cnt : terms accepted since reset/clr, saturating
module fibonacci_checker
  import fib_pkg::*;
#(
  parameter int W           = FIB_W_DEFAULT,
  parameter int CNT_W       = FIB_CNT_W_DEFAULT,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_dual,
  input  logic [W-1:0]     in_data,
  input  logic [W-1:0]     in_data2,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_idx,
  output logic [W-1:0]     err_got,
  output logic [W-1:0]     err_exp,
  output logic [CNT_W-1:0] term_cnt
);

`ifdef FIB_CHECKER_STRICT_SEED_EN
  localparam bit STRICT_SEED = 1'b1;
`else
  localparam bit STRICT_SEED = 1'b0;
`endif

  localparam logic [W-1:0] ONE = {{(W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] x,
                                               input logic [1:0]       inc);
    logic [CNT_W:0] s;
    s = {1'b0, x} + {{(CNT_W-1){1'b0}}, inc};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  fib_state_e       state_q, state_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic             in_ready_q, in_ready_d;
  logic             locked_q, locked_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] err_idx_q, err_idx_d;
  logic [W-1:0]     err_got_q, err_got_d;
  logic [W-1:0]     err_exp_q, err_exp_d;
  logic [CNT_W-1:0] term_cnt_q, term_cnt_d;

  logic [W-1:0] np_exp1, np_exp2;
  logic         xfer, chk0, chk1, m0, m1;
  logic [W-1:0] e0, e1, v0, v1;

  fib_next_pair #(.W(W)) u_next_pair (
    .a    (a_q),
    .b    (b_q),
    .exp1 (np_exp1),
    .exp2 (np_exp2)
  );

  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    err_d      = err_q;
    err_idx_d  = err_idx_q;
    err_got_d  = err_got_q;
    err_exp_d  = err_exp_q;
    term_cnt_d = term_cnt_q;
    chk0       = 1'b0;
    chk1       = 1'b0;
    e0         = '0;
    e1         = '0;
    xfer       = in_valid & in_ready_q;

    // Which terms of this beat are checked, and against what.
    case (state_q)
      SEED0: begin
        chk0 = STRICT_SEED;
        e0   = ONE;
        chk1 = STRICT_SEED & in_dual;
        e1   = ONE;
      end
      SEED1: begin
        chk0 = STRICT_SEED;
        e0   = ONE;
        chk1 = in_dual;
        e1   = a_q + (STRICT_SEED ? ONE : in_data);
      end
      TRACK: begin
        chk0 = 1'b1;
        e0   = np_exp1;
        chk1 = in_dual;
        e1   = np_exp2;
      end
      default: ;
    endcase

    // Checked terms carry their expected value forward so one bad term
    // does not cascade into a stream of follow-on mismatches.
    v0 = chk0 ? e0 : in_data;
    v1 = chk1 ? e1 : in_data2;
    m0 = chk0 && (in_data != e0);
    m1 = chk1 && (in_data2 != e1);

    if (xfer) begin
      term_cnt_d = sat_add(term_cnt_q, in_dual ? 2'd2 : 2'd1);
      case (state_q)
        SEED0: begin
          a_d = v0;
          if (in_dual) begin
            b_d     = v1;
            state_d = TRACK;
          end else begin
            state_d = SEED1;
          end
        end
        SEED1: begin
          if (in_dual) begin
            a_d = v0;
            b_d = v1;
          end else begin
            b_d = v0;
          end
          state_d = TRACK;
        end
        TRACK: begin
          if (in_dual) begin
            a_d = v0;
            b_d = v1;
          end else begin
            a_d = b_q;
            b_d = v0;
          end
        end
        default: ;
      endcase
      // Nothing is checked in FAIL, so this only ever records the first error.
      if (m0 || m1) begin
        state_d = FAIL;
        err_d   = 1'b1;
        if (m0) begin
          err_idx_d = term_cnt_q;
          err_got_d = in_data;
          err_exp_d = e0;
        end else begin
          err_idx_d = sat_add(term_cnt_q, 2'd1);
          err_got_d = in_data2;
          err_exp_d = e1;
        end
      end
    end

    if (clr) begin
      state_d    = SEED0;
      a_d        = '0;
      b_d        = '0;
      err_d      = 1'b0;
      err_idx_d  = '0;
      err_got_d  = '0;
      err_exp_d  = '0;
      term_cnt_d = '0;
    end

    in_ready_d = !(STOP_ON_ERR && (state_d == FAIL));
    locked_d   = (state_d == TRACK);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= SEED0;
      a_q        <= '0;
      b_q        <= '0;
      in_ready_q <= 1'b1;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
      err_idx_q  <= '0;
      err_got_q  <= '0;
      err_exp_q  <= '0;
      term_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      in_ready_q <= in_ready_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
      err_idx_q  <= err_idx_d;
      err_got_q  <= err_got_d;
      err_exp_q  <= err_exp_d;
      term_cnt_q <= term_cnt_d;
    end
  end

  assign in_ready = in_ready_q;
  assign locked   = locked_q;
  assign err      = err_q;
  assign err_idx  = err_idx_q;
  assign err_got  = err_got_q;
  assign err_exp  = err_exp_q;
  assign term_cnt = term_cnt_q;

endmodule
